// File: rtl/drc_hpxl_packer.sv
// -----------------------------------------------------------------------------
// drc_hpxl_packer
//
// Packs the 8-bit half-pixel stream coming out of the DRC capture state
// machine into DMA_DATA_W-wide little-endian words for the DMA write channel.
// The block counts bytes against the frame size latched at the first byte of
// each frame. The final beat of a frame carries m_last and a strobe covering
// only the lanes actually filled. The upstream "last row" flag is checked
// against the packer's own row position, and a mismatch is flagged with a
// one-cycle last_err pulse. The byte counter stays authoritative.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   s_hpxl_dat     half-pixel byte in
//   s_hpxl_last    upstream "in last row of frame" flag
//   s_hpxl_vld     input valid
//   s_hpxl_rdy     input ready (registered, no path from m_rdy)
//   m_dat          packed output word, byte k on lane k
//   m_strb         lane-valid strobe
//   m_last         final beat of frame
//   m_vld          output valid
//   m_rdy          output ready
//   img_width      pixels per row (>=1), sampled at byte 0 of each frame
//   img_height     rows per frame (>=1), sampled at byte 0 of each frame
//   frm_done       one-cycle pulse after the m_last beat handshakes
//   last_err       one-cycle pulse after a byte whose last flag disagrees
// -----------------------------------------------------------------------------
module drc_hpxl_packer #(
    parameter int DVP_DATA_W  = 8,
    parameter int DMA_DATA_W  = 32,
    parameter int IMG_DIM_MAX = 640,
    parameter int IMG_DIM_W   = $clog2(IMG_DIM_MAX),
    parameter int BCNT_W      = 2*IMG_DIM_W + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DVP_DATA_W-1:0]               s_hpxl_dat,
    input  logic                                s_hpxl_last,
    input  logic                                s_hpxl_vld,
    output logic                                s_hpxl_rdy,
    output logic [DMA_DATA_W-1:0]               m_dat,
    output logic [DMA_DATA_W/DVP_DATA_W-1:0]    m_strb,
    output logic                                m_last,
    output logic                                m_vld,
    input  logic                                m_rdy,
    input  logic [IMG_DIM_W-1:0]                img_width,
    input  logic [IMG_DIM_W-1:0]                img_height,
    output logic                                frm_done,
    output logic                                last_err
);

    localparam int LANES  = DMA_DATA_W / DVP_DATA_W;
    localparam int LIDX_W = $clog2(LANES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LANES-1:0][DVP_DATA_W-1:0] acc_dat;
    logic [LANES-1:0]                 acc_strb;
    logic                             acc_last;
    logic                             acc_full;
    logic [LIDX_W-1:0]                lidx;
    logic [BCNT_W-1:0]                bcnt;
    logic [BCNT_W-1:0]                tot;
    logic [BCNT_W-1:0]                row_bytes;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                             s_hsk;
    logic                             m_hsk;
    logic                             frame_start;
    logic [BCNT_W-1:0]                w_ext;
    logic [BCNT_W-1:0]                h_ext;
    logic [BCNT_W-1:0]                csr_tot;
    logic [BCNT_W-1:0]                csr_row;
    logic [BCNT_W-1:0]                eff_tot;
    logic [BCNT_W-1:0]                eff_row;
    logic                             final_byte;
    logic                             word_done;
    logic                             exp_last;
    logic                             stage_free;
    logic [LANES-1:0][DVP_DATA_W-1:0] acc_dat_wr;
    logic [LANES-1:0]                 acc_strb_wr;

    assign s_hsk       = s_hpxl_vld & s_hpxl_rdy;
    assign m_hsk       = m_vld & m_rdy;
    assign frame_start = (bcnt == '0);

    // Frame geometry straight from the CSRs. It is only used on byte 0.
    // After that the latched copies rule, so CSR edits mid-frame are
    // deferred to the next frame.
    assign w_ext   = BCNT_W'(img_width);
    assign h_ext   = BCNT_W'(img_height);
    assign csr_row = w_ext << 1;
    assign csr_tot = (w_ext * h_ext) << 1;

    // Byte 0 must already see the new frame's size, because the latch
    // only lands at the end of that cycle.
    assign eff_tot = frame_start ? csr_tot : tot;
    assign eff_row = frame_start ? csr_row : row_bytes;

    assign final_byte = (bcnt == eff_tot - BCNT_W'(1));
    assign word_done  = s_hsk & ((lidx == LIDX_W'(LANES-1)) | final_byte);
    assign exp_last   = (bcnt >= eff_tot - eff_row);
    assign stage_free = ~m_vld | m_hsk;

    // Accumulator contents as they would be with the current byte merged in.
    always_comb begin
        acc_dat_wr        = acc_dat;
        acc_strb_wr       = acc_strb;
        acc_dat_wr[lidx]  = s_hpxl_dat;
        acc_strb_wr[lidx] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Frame bookkeeping: byte counter, lane index, latched size
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt      <= '0;
            lidx      <= '0;
            tot       <= '0;
            row_bytes <= '0;
        end else if (s_hsk) begin
            if (frame_start) begin
                tot       <= csr_tot;
                row_bytes <= csr_row;
            end
            if (final_byte) begin
                bcnt <= '0;
                lidx <= '0;
            end else begin
                bcnt <= bcnt + BCNT_W'(1);
                // LANES is a power of two, so the index wraps to lane 0
                // by itself when a full word completes.
                lidx <= lidx + LIDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator and output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_dat    <= '0;
            acc_strb   <= '0;
            acc_last   <= 1'b0;
            acc_full   <= 1'b0;
            s_hpxl_rdy <= 1'b1;
            m_dat      <= '0;
            m_strb     <= '0;
            m_last     <= 1'b0;
            m_vld      <= 1'b0;
        end else begin
            if (m_hsk) begin
                m_vld <= 1'b0;
            end

            if (acc_full) begin
                // A completed word is parked here. It moves into the stage
                // as soon as the current beat leaves. Ready comes back one
                // cycle later through the register.
                if (m_hsk) begin
                    m_dat      <= acc_dat;
                    m_strb     <= acc_strb;
                    m_last     <= acc_last;
                    m_vld      <= 1'b1;
                    acc_dat    <= '0;
                    acc_strb   <= '0;
                    acc_last   <= 1'b0;
                    acc_full   <= 1'b0;
                    s_hpxl_rdy <= 1'b1;
                end
            end else if (s_hsk) begin
                if (word_done) begin
                    if (stage_free) begin
                        m_dat    <= acc_dat_wr;
                        m_strb   <= acc_strb_wr;
                        m_last   <= final_byte;
                        m_vld    <= 1'b1;
                        acc_dat  <= '0;
                        acc_strb <= '0;
                        acc_last <= 1'b0;
                    end else begin
                        acc_dat    <= acc_dat_wr;
                        acc_strb   <= acc_strb_wr;
                        acc_last   <= final_byte;
                        acc_full   <= 1'b1;
                        s_hpxl_rdy <= 1'b0;
                    end
                end else begin
                    acc_dat  <= acc_dat_wr;
                    acc_strb <= acc_strb_wr;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_done <= 1'b0;
            last_err <= 1'b0;
        end else begin
            frm_done <= m_hsk & m_last;
            last_err <= s_hsk & (s_hpxl_last != exp_last);
        end
    end

endmodule

// File: tb/tb_drc_hpxl_packer.sv
module tb_drc_hpxl_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_hpxl_dat;
    logic        s_hpxl_last;
    logic        s_hpxl_vld;
    logic        s_hpxl_rdy;
    logic [31:0] m_dat;
    logic [3:0]  m_strb;
    logic        m_last;
    logic        m_vld;
    logic        m_rdy;
    logic [9:0]  img_width;
    logic [9:0]  img_height;
    logic        frm_done;
    logic        last_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_err   = 0;

    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    drc_hpxl_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_hpxl_dat  (s_hpxl_dat),
        .s_hpxl_last (s_hpxl_last),
        .s_hpxl_vld  (s_hpxl_vld),
        .s_hpxl_rdy  (s_hpxl_rdy),
        .m_dat       (m_dat),
        .m_strb      (m_strb),
        .m_last      (m_last),
        .m_vld       (m_vld),
        .m_rdy       (m_rdy),
        .img_width   (img_width),
        .img_height  (img_height),
        .frm_done    (frm_done),
        .last_err    (last_err)
    );

    always #5 clk = ~clk;

    // Beats and pulses are observed mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_vld && m_rdy) got_q.push_back({m_last, m_strb, m_dat});
            if (frm_done) n_done++;
            if (last_err) n_err++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] bt(input logic [31:0] d, input logic [3:0] s, input logic l);
        return {l, s, d};
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic lst);
        int guard;
        guard = 0;
        s_hpxl_dat  = d;
        s_hpxl_last = lst;
        s_hpxl_vld  = 1'b1;
        @(negedge clk);
        while (!s_hpxl_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("rdy_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_hpxl_vld = 1'b0;
    endtask

    // Sends nb bytes base, base+1, ... with the last flag set for the final
    // row (row bytes per row); byte index 'bad' gets its flag inverted.
    task automatic send_frame(input int nb, input int row, input logic [7:0] base, input int bad);
        logic lst;
        for (int i = 0; i < nb; i++) begin
            lst = (i >= nb - row);
            if (i == bad) lst = ~lst;
            send_byte(base + 8'(i), lst);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_counts();
        got_q.delete();
        exp_q.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    initial begin
        rst_n       = 1'b0;
        s_hpxl_dat  = 8'h00;
        s_hpxl_last = 1'b0;
        s_hpxl_vld  = 1'b0;
        m_rdy       = 1'b1;
        img_width   = 10'd4;
        img_height  = 10'd2;
        idle(3);

        // Reset state
        chk("rst_m_vld",    64'(m_vld),      64'd0);
        chk("rst_rdy",      64'(s_hpxl_rdy), 64'd1);
        chk("rst_m_dat",    64'(m_dat),      64'd0);
        chk("rst_m_strb",   64'(m_strb),     64'd0);
        chk("rst_m_last",   64'(m_last),     64'd0);
        chk("rst_frm_done", 64'(frm_done),   64'd0);
        chk("rst_last_err", 64'(last_err),   64'd0);
        rst_n = 1'b1;
        idle(2);

        // W=4,H=2 : 16 bytes, four full beats
        clear_counts();
        exp_q.push_back(bt(32'h03020100, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h07060504, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h0B0A0908, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h0F0E0D0C, 4'hF, 1'b1));
        send_frame(16, 8, 8'h00, -1);
        idle(5);
        check_beats("w4h2");
        chk("w4h2_frm_done", 64'(n_done), 64'd1);
        chk("w4h2_last_err", 64'(n_err),  64'd0);

        // W=3,H=1 : partial final beat
        clear_counts();
        img_width  = 10'd3;
        img_height = 10'd1;
        exp_q.push_back(bt(32'hA3A2A1A0, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h0000A5A4, 4'h3, 1'b1));
        send_frame(6, 6, 8'hA0, -1);
        idle(5);
        check_beats("w3h1");
        chk("w3h1_frm_done", 64'(n_done), 64'd1);
        chk("w3h1_last_err", 64'(n_err),  64'd0);

        // W=4,H=2 with output stalled for 10 cycles
        clear_counts();
        img_width  = 10'd4;
        img_height = 10'd2;
        exp_q.push_back(bt(32'h13121110, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h17161514, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h1B1A1918, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h1F1E1D1C, 4'hF, 1'b1));
        m_rdy = 1'b0;
        fork
            send_frame(16, 8, 8'h10, -1);
            begin
                repeat (9) @(posedge clk);
                @(negedge clk);
                chk("stall_m_vld", 64'(m_vld),      64'd1);
                chk("stall_m_dat", 64'(m_dat),      64'h13121110);
                chk("stall_rdy",   64'(s_hpxl_rdy), 64'd0);
                @(posedge clk);
                #1;
                m_rdy = 1'b1;
            end
        join
        idle(5);
        check_beats("stall");
        chk("stall_frm_done", 64'(n_done), 64'd1);

        // W=2,H=2 with a wrong last flag on byte 2
        clear_counts();
        img_width  = 10'd2;
        img_height = 10'd2;
        exp_q.push_back(bt(32'h23222120, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h27262524, 4'hF, 1'b1));
        send_frame(8, 4, 8'h20, 2);
        idle(5);
        check_beats("lerr");
        chk("lerr_count",    64'(n_err),  64'd1);
        chk("lerr_frm_done", 64'(n_done), 64'd1);

        // Width changed mid-frame: current frame keeps 16 bytes
        clear_counts();
        img_width  = 10'd4;
        img_height = 10'd2;
        exp_q.push_back(bt(32'h33323130, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h37363534, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h3B3A3938, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h3F3E3D3C, 4'hF, 1'b1));
        exp_q.push_back(bt(32'h43424140, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h47464544, 4'hF, 1'b1));
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h30 + 8'(i), (i >= 8));
            if (i == 5) img_width = 10'd2;
        end
        send_frame(8, 4, 8'h40, -1);
        idle(5);
        check_beats("csr");
        chk("csr_frm_done", 64'(n_done), 64'd2);
        chk("csr_last_err", 64'(n_err),  64'd0);

        // Reset after byte 6 of a frame, then a fresh frame
        clear_counts();
        img_width  = 10'd4;
        img_height = 10'd2;
        send_frame(7, 8, 8'h50, -1);
        rst_n = 1'b0;
        idle(2);
        chk("mrst_m_vld", 64'(m_vld),      64'd0);
        chk("mrst_rdy",   64'(s_hpxl_rdy), 64'd1);
        chk("mrst_strb",  64'(m_strb),     64'd0);
        rst_n = 1'b1;
        idle(1);
        clear_counts();
        img_width  = 10'd3;
        img_height = 10'd1;
        exp_q.push_back(bt(32'hB3B2B1B0, 4'hF, 1'b0));
        exp_q.push_back(bt(32'h0000B5B4, 4'h3, 1'b1));
        send_frame(6, 6, 8'hB0, -1);
        idle(5);
        check_beats("mrst");
        chk("mrst_frm_done", 64'(n_done), 64'd1);
        chk("mrst_last_err", 64'(n_err),  64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
